// File: rtl/centroid_pkg.sv
// Shared types and width constants for the centroid datapath: the moment
// accumulators, the divider wrapper and the division scheduler.
package centroid_pkg;

  localparam int COORD_W = 11;
  localparam int MOM_W   = 32;
  localparam int M00_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_X = 3'd1,
    ST_WAIT_X  = 3'd2,
    ST_START_Y = 3'd3,
    ST_WAIT_Y  = 3'd4
  } cds_state_t;

endpackage

// File: rtl/centroid_div_sched.sv
// Centroid division scheduler: snapshots the moment sums at end-of-frame and
// runs x = m10/m00 then y = m01/m00 on one shared divider, publishing x/y
// together with a one-cycle valid pulse. A watchdog aborts a sequence when
// the divider never answers.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for eof; x/y hold the last published centroid
// ST_START_X | div_start pulse for m10_r / m00_r
// ST_WAIT_X  | waiting for the x quotient (watchdog running)
// ST_START_Y | div_start pulse for m01_r / m00_r
// ST_WAIT_Y  | waiting for the y quotient (watchdog running)
module centroid_div_sched
  import centroid_pkg::*;
#(
  parameter int COORD_W = centroid_pkg::COORD_W,
  parameter int MOM_W   = centroid_pkg::MOM_W,
  parameter int M00_W   = centroid_pkg::M00_W,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eof,
  input  logic [MOM_W-1:0]   m10,
  input  logic [MOM_W-1:0]   m01,
  input  logic [M00_W-1:0]   m00,
  output logic               div_start,
  output logic [MOM_W-1:0]   div_dividend,
  output logic [M00_W-1:0]   div_divisor,
  input  logic [MOM_W-1:0]   div_quotient,
  input  logic               div_qv,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               valid,
  output logic               busy,
  output logic               empty,
  output logic               overrun,
  output logic               err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  cds_state_t state, state_nxt;

  logic [MOM_W-1:0]   m10_r, m01_r;
  logic [M00_W-1:0]   m00_r;
  logic [COORD_W-1:0] x_tmp;
  logic [CNT_W-1:0]   wd_cnt;
  logic               wd_last;
  logic [COORD_W-1:0] q_sat;

  logic start_nxt, valid_nxt, empty_nxt, overrun_nxt, err_nxt, busy_nxt;
  logic load_snap, cap_x, cap_y;

  // Quotients above the coordinate range clamp to all-ones instead of wrapping.
  function automatic logic [COORD_W-1:0] sat(input logic [MOM_W-1:0] q);
    if (|q[MOM_W-1:COORD_W]) return '1;
    else return q[COORD_W-1:0];
  endfunction

  assign q_sat   = sat(div_quotient);
  assign wd_last = (wd_cnt == CNT_W'(TIMEOUT - 1));

  // Divider operands come straight from the snapshots so they stay stable
  // from the start pulse until the matching quotient.
  always_comb begin
    div_divisor  = m00_r;
    div_dividend = m10_r;
    if (state == ST_START_Y || state == ST_WAIT_Y) div_dividend = m01_r;
  end

  // Next-state logic; a quotient outranks a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (eof && m00 != '0) state_nxt = ST_START_X;
      ST_START_X: state_nxt = ST_WAIT_X;
      ST_WAIT_X: begin
        if (div_qv)       state_nxt = ST_START_Y;
        else if (wd_last) state_nxt = ST_IDLE;
      end
      ST_START_Y: state_nxt = ST_WAIT_Y;
      ST_WAIT_Y: begin
        if (div_qv)       state_nxt = ST_IDLE;
        else if (wd_last) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered pulses and capture enables.
  always_comb begin
    load_snap   = (state == ST_IDLE) && eof && (m00 != '0);
    cap_x       = (state == ST_WAIT_X) && div_qv;
    cap_y       = (state == ST_WAIT_Y) && div_qv;
    start_nxt   = (state_nxt == ST_START_X) || (state_nxt == ST_START_Y);
    valid_nxt   = cap_y;
    empty_nxt   = (state == ST_IDLE) && eof && (m00 == '0);
    overrun_nxt = (state != ST_IDLE) && eof;
    err_nxt     = (state == ST_WAIT_X || state == ST_WAIT_Y) && !div_qv && wd_last;
    busy_nxt    = (state_nxt != ST_IDLE);
  end

  // State register plus registered outputs, snapshots and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_start <= 1'b0;
      valid     <= 1'b0;
      empty     <= 1'b0;
      overrun   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      m10_r     <= '0;
      m01_r     <= '0;
      m00_r     <= '0;
      x_tmp     <= '0;
      x         <= '0;
      y         <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      div_start <= start_nxt;
      valid     <= valid_nxt;
      empty     <= empty_nxt;
      overrun   <= overrun_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      if (load_snap) begin
        m10_r <= m10;
        m01_r <= m01;
        m00_r <= m00;
      end
      if (cap_x) x_tmp <= q_sat;
      if (cap_y) begin
        x <= x_tmp;
        y <= q_sat;
      end
      // Clearing in the START states means every WAIT begins at zero.
      if (state == ST_START_X || state == ST_START_Y) wd_cnt <= '0;
      else if ((state == ST_WAIT_X || state == ST_WAIT_Y) && !wd_last)
        wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched with a behavioural divider of
// latency LAT (qv high LAT cycles after the start cycle).
module tb_centroid_div_sched;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eof = 1'b0;
  logic [31:0] m10 = '0;
  logic [31:0] m01 = '0;
  logic [19:0] m00 = '0;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [19:0] div_divisor;
  logic [31:0] div_quotient;
  logic        div_qv;
  logic [10:0] x, y;
  logic        valid, busy, empty, overrun, err;

  int checks = 0;
  int errors = 0;
  bit never_answer = 1'b0;

  centroid_div_sched #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .eof(eof),
    .m10(m10), .m01(m01), .m00(m00),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .x(x), .y(y), .valid(valid), .busy(busy),
    .empty(empty), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural divider: latches operands on div_start, answers LAT cycles later.
  int          dcnt;
  logic [31:0] q_hold;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt         <= 0;
      q_hold       <= '0;
      div_qv       <= 1'b0;
      div_quotient <= '0;
    end else begin
      div_qv <= 1'b0;
      if (div_start) begin
        q_hold <= div_dividend / 32'(div_divisor);
        dcnt   <= LAT - 1;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1 && !never_answer) begin
          div_qv       <= 1'b1;
          div_quotient <= q_hold;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drives eof in cycle 0 (caller is at a negedge) and observes 100 cycles.
  // Cycle numbers of the first valid/empty/overrun/err are returned (-1 = none).
  task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [19:0] c,
                           input int ovr_at,
                           output int v_cyc, output int e_cyc, output int o_cyc,
                           output int r_cyc, output int n_start, output int n_valid,
                           output logic [31:0] d1, output logic [31:0] d2,
                           output logic busy1, output logic busy70);
    v_cyc = -1; e_cyc = -1; o_cyc = -1; r_cyc = -1;
    n_start = 0; n_valid = 0; d1 = '1; d2 = '1; busy1 = 1'b0; busy70 = 1'b0;
    m10 = a; m01 = b; m00 = c; eof = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == ovr_at) begin
        eof = 1'b1; m10 = 32'd9999; m01 = 32'd8888; m00 = 20'd3;
      end else begin
        eof = 1'b0;
      end
      if (valid) begin
        n_valid++;
        if (v_cyc < 0) v_cyc = cyc;
      end
      if (empty   && e_cyc < 0) e_cyc = cyc;
      if (overrun && o_cyc < 0) o_cyc = cyc;
      if (err     && r_cyc < 0) r_cyc = cyc;
      if (div_start) begin
        if (n_start == 0) d1 = div_dividend;
        if (n_start == 1) d2 = div_dividend;
        n_start++;
      end
      if (cyc == 1)  busy1  = busy;
      if (cyc == 70) busy70 = busy;
    end
  endtask

  int vc, ec, oc, rc, ns, nv;
  logic [31:0] d1, d2;
  logic b1, b70;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", {27'd0, valid, empty, overrun, err, div_start}, 0);

    // Nominal frame.
    run_frame(32'd6400, 32'd3200, 20'd100, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("a_valid_cyc", vc, 71);
    check("a_valid_cnt", nv, 1);
    check("a_starts", ns, 2);
    check("a_dividend_x", d1, 6400);
    check("a_dividend_y", d2, 3200);
    check("a_divisor", 32'(div_divisor), 100);
    check("a_x", 32'(x), 64);
    check("a_y", 32'(y), 32);
    check("a_busy1", 32'(b1), 1);
    check("a_busy70", 32'(b70), 1);
    check("a_busy_end", 32'(busy), 0);

    // Empty frame: no division, x/y hold.
    run_frame(32'd500, 32'd700, 20'd0, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("e_empty_cyc", ec, 1);
    check("e_starts", ns, 0);
    check("e_valid_cyc", vc, -1);
    check("e_x_hold", 32'(x), 64);
    check("e_y_hold", 32'(y), 32);

    // Second eof in cycle 10 is dropped.
    run_frame(32'd1000, 32'd2000, 20'd10, 10, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("o_overrun_cyc", oc, 11);
    check("o_starts", ns, 2);
    check("o_valid_cyc", vc, 71);
    check("o_x", 32'(x), 100);
    check("o_y", 32'(y), 200);

    // Saturation.
    run_frame(32'd5000, 32'd3000, 20'd1, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("s_x", 32'(x), 2047);
    check("s_y", 32'(y), 2047);

    // Boundary: 2046 passes through, 2048 clamps to 2047.
    run_frame(32'd6138, 32'd6144, 20'd3, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("b_x_2046", 32'(x), 2046);
    check("b_y_2048", 32'(y), 2047);

    // Divider never answers: watchdog fires, x/y unchanged.
    never_answer = 1'b1;
    run_frame(32'd300, 32'd500, 20'd10, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("t_err_cyc", rc, 66);
    check("t_valid_cyc", vc, -1);
    check("t_starts", ns, 1);
    check("t_busy_end", 32'(busy), 0);
    check("t_x_hold", 32'(x), 2046);
    check("t_y_hold", 32'(y), 2047);
    never_answer = 1'b0;
    run_frame(32'd300, 32'd500, 20'd10, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("t2_valid_cyc", vc, 71);
    check("t2_x", 32'(x), 30);
    check("t2_y", 32'(y), 50);

    // Reset while waiting for the x quotient.
    m10 = 32'd4000; m01 = 32'd4000; m00 = 20'd4; eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_x", 32'(x), 0);
    check("r_y", 32'(y), 0);
    check("r_busy", 32'(busy), 0);
    check("r_pulses", {27'd0, valid, empty, overrun, err, div_start}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(32'd700, 32'd1400, 20'd7, -1, vc, ec, oc, rc, ns, nv, d1, d2, b1, b70);
    check("r2_valid_cyc", vc, 71);
    check("r2_x", 32'(x), 100);
    check("r2_y", 32'(y), 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
